pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_if.sv | 54 +++++
 rtl/pipeline_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : Bundle between the 5-stage pipeline datapath and its hazard
//               controller.
//               master - pipeline side: drives hazard inputs, receives the
//                        stage enables/clears, the halted flag and counters.
//               slave  - controller side (pipeline_hazard_ctrl).
//               Inputs : ID_rs, ID_rt, ID_use_rs, ID_use_rt, EX_RegWrite,
//                        EX_MemtoReg, EX_WbRegNum, EX_redirect, EX_SYSCALL,
//                        EX_halt_req, resume
//               Outputs: PC_EN, IFID_EN, IFID_CLR, IDEX_EN, IDEX_CLR,
//                        EXMEM_EN, halted, cycle_cnt, stall_cnt, flush_cnt
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        ID_use_rs;
  logic        ID_use_rt;
  logic        EX_RegWrite;
  logic        EX_MemtoReg;
  logic [4:0]  EX_WbRegNum;
  logic        EX_redirect;
  logic        EX_SYSCALL;
  logic        EX_halt_req;
  logic        resume;

  logic        PC_EN;
  logic        IFID_EN;
  logic        IFID_CLR;
  logic        IDEX_EN;
  logic        IDEX_CLR;
  logic        EXMEM_EN;
  logic        halted;
  logic [31:0] cycle_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output ID_rs, ID_rt, ID_use_rs, ID_use_rt, EX_RegWrite, EX_MemtoReg,
           EX_WbRegNum, EX_redirect, EX_SYSCALL, EX_halt_req, resume,
    input  PC_EN, IFID_EN, IFID_CLR, IDEX_EN, IDEX_CLR, EXMEM_EN, halted,
           cycle_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_rs, ID_rt, ID_use_rs, ID_use_rt, EX_RegWrite, EX_MemtoReg,
           EX_WbRegNum, EX_redirect, EX_SYSCALL, EX_halt_req, resume,
    output PC_EN, IFID_EN, IFID_CLR, IDEX_EN, IDEX_CLR, EXMEM_EN, halted,
           cycle_cnt, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Hazard / halt controller for a 5-stage pipeline.
//               Detects load-use hazards (one bubble), flushes IF/ID and ID/EX
//               on a redirect resolved in EX, and on a halting syscall lets
//               the syscall drain through two cycles before entering HALT.
//               Keeps saturating cycle, stall and flush counters.
//               Ports : clk - rising-edge clock
//                       rst - asynchronous active-high reset
//                       hz  - pipeline_hazard_ctrl_if.slave (hazard inputs,
//                             stage enables/clears, halted, counters)
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN1 = 2'd1,
    S_DRAIN2 = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

  state_t      r_state;
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_load_use;
  logic w_halt_ev;
  logic w_flush_ev;
  logic w_stall_ev;
  logic w_halt_take;

  logic w_pc_en;
  logic w_ifid_en;
  logic w_ifid_clr;
  logic w_idex_en;
  logic w_idex_clr;
  logic w_exmem_en;

  // A load writing $zero produces nothing to forward-wait on.
  assign w_rs_hit   = hz.ID_use_rs && (hz.ID_rs == hz.EX_WbRegNum);
  assign w_rt_hit   = hz.ID_use_rt && (hz.ID_rt == hz.EX_WbRegNum);
  assign w_load_use = hz.EX_MemtoReg && hz.EX_RegWrite &&
                      (hz.EX_WbRegNum != 5'd0) && (w_rs_hit || w_rt_hit);
  assign w_halt_ev  = hz.EX_SYSCALL && hz.EX_halt_req;

  // Priority in RUN: redirect > halt > load-use.
  assign w_flush_ev  = (r_state == S_RUN) && hz.EX_redirect;
  assign w_halt_take = (r_state == S_RUN) && !hz.EX_redirect && w_halt_ev;
  assign w_stall_ev  = (r_state == S_RUN) && !hz.EX_redirect && !w_halt_ev &&
                       w_load_use;

  always_comb begin
    w_pc_en    = 1'b1;
    w_ifid_en  = 1'b1;
    w_ifid_clr = 1'b0;
    w_idex_en  = 1'b1;
    w_idex_clr = 1'b0;
    w_exmem_en = 1'b1;
    if (rst) begin
      // Keep every stage clocking so the clears zero the pipeline registers.
      w_ifid_clr = 1'b1;
      w_idex_clr = 1'b1;
    end else begin
      case (r_state)
        S_RUN: begin
          if (hz.EX_redirect || w_halt_ev) begin
            w_ifid_clr = 1'b1;
            w_idex_clr = 1'b1;
          end else if (w_load_use) begin
            w_pc_en    = 1'b0;
            w_ifid_en  = 1'b0;
            w_idex_clr = 1'b1;
          end
        end
        S_DRAIN1, S_DRAIN2: begin
          // Front end frozen, bubbles behind the draining syscall.
          w_pc_en    = 1'b0;
          w_ifid_en  = 1'b0;
          w_idex_clr = 1'b1;
        end
        S_HALT: begin
          w_pc_en   = 1'b0;
          w_ifid_en = 1'b0;
          w_idex_en = 1'b0;
        end
        default: begin
          w_pc_en   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_cycle_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      case (r_state)
        S_RUN:    if (w_halt_take) r_state <= S_DRAIN1;
        S_DRAIN1: r_state <= S_DRAIN2;
        S_DRAIN2: r_state <= S_HALT;
        S_HALT:   if (hz.resume) r_state <= S_RUN;
        default:  r_state <= S_RUN;
      endcase

      if ((r_state != S_HALT) && (r_cycle_cnt != C_CNT_MAX))
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_stall_ev && (r_stall_cnt != C_CNT_MAX))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush_ev && (r_flush_cnt != C_CNT_MAX))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign hz.PC_EN     = w_pc_en;
  assign hz.IFID_EN   = w_ifid_en;
  assign hz.IFID_CLR  = w_ifid_clr;
  assign hz.IDEX_EN   = w_idex_en;
  assign hz.IDEX_CLR  = w_idex_clr;
  assign hz.EXMEM_EN  = w_exmem_en;
  assign hz.halted    = (r_state == S_HALT);
  assign hz.cycle_cnt = r_cycle_cnt;
  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench for pipeline_hazard_ctrl.
//               Expected control vectors and counter values are queued when
//               a step is driven and popped when the outputs are sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  // Control vector order: {PC_EN, IFID_EN, IFID_CLR, IDEX_EN, IDEX_CLR, EXMEM_EN, halted}
  localparam logic [6:0] C_NORM  = 7'b1101010;
  localparam logic [6:0] C_FLUSH = 7'b1111110;
  localparam logic [6:0] C_STALL = 7'b0001110;
  localparam logic [6:0] C_DRAIN = 7'b0001110;
  localparam logic [6:0] C_HALT  = 7'b0000011;
  localparam logic [6:0] C_RST   = 7'b1111110;
  localparam logic [31:0] C_MAX  = 32'hFFFF_FFFF;

  typedef struct {
    string       tag;
    logic [6:0]  ctl;
    logic [31:0] cyc;
    logic [31:0] stl;
    logic [31:0] fl;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] e_cyc = 32'd0;
  logic [31:0] e_stl = 32'd0;
  logic [31:0] e_fl  = 32'd0;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == C_MAX) ? v : v + 32'd1;
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic regw,
                       input logic m2r, input logic [4:0] wb,
                       input logic redir, input logic sys, input logic hreq,
                       input logic res);
    hz.ID_rs       = rs;
    hz.ID_rt       = rt;
    hz.ID_use_rs   = urs;
    hz.ID_use_rt   = urt;
    hz.EX_RegWrite = regw;
    hz.EX_MemtoReg = m2r;
    hz.EX_WbRegNum = wb;
    hz.EX_redirect = redir;
    hz.EX_SYSCALL  = sys;
    hz.EX_halt_req = hreq;
    hz.resume      = res;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cmp(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp_v);
    end
  endtask

  // Queue the expectation for the inputs just driven, then sample 1 ns later.
  task automatic expect_now(input string tag, input logic [6:0] ctl);
    exp_t e;
    logic [6:0] obs;
    e.tag = tag;
    e.ctl = ctl;
    e.cyc = e_cyc;
    e.stl = e_stl;
    e.fl  = e_fl;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    obs = {hz.PC_EN, hz.IFID_EN, hz.IFID_CLR, hz.IDEX_EN, hz.IDEX_CLR,
           hz.EXMEM_EN, hz.halted};
    cmp(e.tag, "ctl",       {25'd0, obs}, {25'd0, e.ctl});
    cmp(e.tag, "cycle_cnt", hz.cycle_cnt, e.cyc);
    cmp(e.tag, "stall_cnt", hz.stall_cnt, e.stl);
    cmp(e.tag, "flush_cnt", hz.flush_cnt, e.fl);
  endtask

  // Advance one edge; counters move only when reset is released.
  task automatic tick(input bit was_halt, input bit dstall, input bit dflush);
    @(posedge clk);
    if (!rst) begin
      if (!was_halt) e_cyc = sat_inc(e_cyc);
      if (dstall)    e_stl = sat_inc(e_stl);
      if (dflush)    e_fl  = sat_inc(e_fl);
    end
    @(negedge clk);
  endtask

  task automatic go_halt();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_now("halt_ev", C_FLUSH);
    tick(0, 0, 0);
    idle();
    expect_now("drain1", C_DRAIN);
    tick(0, 0, 0);
    expect_now("drain2", C_DRAIN);
    tick(0, 0, 0);
    expect_now("halted", C_HALT);
    tick(1, 0, 0);
  endtask

  initial begin
    idle();
    #1 rst = 1'b1;
    expect_now("reset_async", C_RST);
    tick(0, 0, 0);
    expect_now("reset_held", C_RST);
    rst = 1'b0;
    expect_now("run_idle0", C_NORM);
    tick(0, 0, 0);
    expect_now("run_idle1", C_NORM);
    tick(0, 0, 0);

    // Load-use on rs: exactly one bubble.
    drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_now("lu_rs", C_STALL);
    tick(0, 1, 0);
    idle();
    expect_now("lu_rs_after", C_NORM);
    tick(0, 0, 0);

    // Load-use on rt.
    drive(5'd0, 5'd17, 1'b0, 1'b1, 1'b1, 1'b1, 5'd17, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_now("lu_rt", C_STALL);
    tick(0, 1, 0);

    // No hazard: $zero destination, rs unused, not a write, not a load, no match.
    drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_now("lu_zero", C_NORM);
    tick(0, 0, 0);
    drive(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_now("lu_nouse", C_NORM);
    tick(0, 0, 0);
    drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_now("lu_noregw", C_NORM);
    tick(0, 0, 0);
    drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_now("lu_noload", C_NORM);
    tick(0, 0, 0);
    drive(5'd9, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_now("lu_nomatch", C_NORM);
    tick(0, 0, 0);

    // Redirect wins over a simultaneous load-use.
    drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_now("redir_lu", C_FLUSH);
    tick(0, 0, 1);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_now("redir_halt", C_FLUSH);
    tick(0, 0, 1);

    // Syscall without halt request is ordinary.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_now("sys_nohalt", C_NORM);
    tick(0, 0, 0);

    // Halt sequence; inputs during drain are ignored.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    expect_now("halt_ev", C_FLUSH);
    tick(0, 0, 0);
    drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_now("drain1_ign", C_DRAIN);
    tick(0, 0, 0);
    drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_now("drain2_ign", C_DRAIN);
    tick(0, 0, 0);
    drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_now("halt0", C_HALT);
    tick(1, 0, 0);
    idle();
    expect_now("halt_frozen", C_HALT);
    tick(1, 0, 0);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_now("halt_resume", C_HALT);
    tick(1, 0, 0);
    idle();
    expect_now("resumed", C_NORM);
    tick(0, 0, 0);
    expect_now("resumed_cnt", C_NORM);
    tick(0, 0, 0);

    // Reset while halted.
    go_halt();
    rst = 1'b1;
    e_cyc = 32'd0;
    e_stl = 32'd0;
    e_fl  = 32'd0;
    expect_now("rst_in_halt", C_RST);
    tick(0, 0, 0);
    rst = 1'b0;
    expect_now("after_rst_halt", C_NORM);
    tick(0, 0, 0);

    // Reset in the middle of the drain.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_now("halt_ev2", C_FLUSH);
    tick(0, 0, 0);
    idle();
    rst = 1'b1;
    e_cyc = 32'd0;
    expect_now("rst_in_drain", C_RST);
    tick(0, 0, 0);
    rst = 1'b0;
    expect_now("after_rst_drain", C_NORM);
    tick(0, 0, 0);
    expect_now("after_rst_drain1", C_NORM);
    tick(0, 0, 0);

    // Saturation of the cycle counter.
    force dut.r_cycle_cnt = C_MAX;
    #1;
    release dut.r_cycle_cnt;
    e_cyc = C_MAX;
    expect_now("sat_preload", C_NORM);
    tick(0, 0, 0);
    expect_now("sat_hold1", C_NORM);
    tick(0, 0, 0);
    expect_now("sat_hold2", C_NORM);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
